// File: rtl/pair_triple_stim_gen.sv
// Stimulus source for the pair/triple detector: sweeps all 3-bit patterns over valid/ready
// and presents the expected majority result. Define PATGEN_GRAY_EN for Gray-order sweeps.
module pair_triple_stim_gen #(
  parameter int REPW = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [REPW-1:0] reps,
  output logic            out0,
  output logic            out1,
  output logic            out2,
  output logic            out_val,
  input  logic            out_rdy,
  output logic            exp,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] pair_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_d;
  logic [2:0]      idx, idx_d;
  logic [REPW-1:0] rem, rem_d;
  logic [CNTW-1:0] cnt, cnt_d;
  logic [2:0]      seq_pat;
  logic [2:0]      pat;
  logic            xfer;

`ifdef PATGEN_GRAY_EN
  assign seq_pat = idx ^ (idx >> 1);
`else
  assign seq_pat = idx;
`endif

  // Pattern lines are forced low outside RUN so the detector sees a quiet bus.
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign pat        = busy ? seq_pat : 3'b000;
  assign out0       = pat[0];
  assign out1       = pat[1];
  assign out2       = pat[2];
  assign out_val    = busy;
  assign exp        = (pat[0] & pat[1]) | (pat[0] & pat[2]) | (pat[1] & pat[2]);
  assign xfer       = busy & out_rdy;
  assign pair_count = cnt;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state;
    idx_d   = idx;
    rem_d   = rem;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (start && (reps != '0)) begin
          rem_d   = reps;
          idx_d   = 3'd0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (exp && (cnt != '1)) cnt_d = cnt + CNTW'(1);
          if (idx == 3'd7) begin
            rem_d = rem - REPW'(1);
            idx_d = 3'd0;
            if (rem == REPW'(1)) state_d = DONE;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 3'd0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      rem   <= rem_d;
      cnt   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pair_triple_stim_gen.sv
// Randomized self-checking bench for pair_triple_stim_gen against a transfer-count model;
// a second instance with CNTW=2 covers counter saturation.
module tb_pair_triple_stim_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] reps;
  logic       out_rdy;

  logic       o0, o1, o2, val, ex, busy, done;
  logic [7:0] pc;
  logic       b_o0, b_o1, b_o2, b_val, b_ex, b_busy, b_done;
  logic [1:0] b_pc;

  pair_triple_stim_gen #(.REPW(4), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reps(reps),
    .out0(o0), .out1(o1), .out2(o2), .out_val(val), .out_rdy(out_rdy),
    .exp(ex), .busy(busy), .done(done), .pair_count(pc)
  );

  pair_triple_stim_gen #(.REPW(4), .CNTW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .reps(reps),
    .out0(b_o0), .out1(b_o1), .out2(b_o2), .out_val(b_val), .out_rdy(out_rdy),
    .exp(b_ex), .busy(b_busy), .done(b_done), .pair_count(b_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 idle, 1 running, 2 done; t counts transfers into the run.
  int ph, t, total, cnt;
  int seq_tab[8];
  int dut_acc[$];
  int done_cnt, busy_cnt;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic tick();
    if (val && out_rdy) dut_acc.push_back(int'({o2, o1, o0}));
    @(posedge clk);
    if (!rst_n) begin
      ph = 0; t = 0; cnt = 0;
    end else begin
      case (ph)
        0: if (start && reps != 0) begin
             ph = 1; t = 0; total = 8 * int'(reps); cnt = 0;
           end
        1: if (out_rdy) begin
             if ($countones(seq_tab[t % 8]) >= 2) cnt++;
             t++;
             if (t == total) ph = 2;
           end
        default: ph = 0;
      endcase
    end
    #1;
    begin
      int ep;
      ep = (ph == 1) ? seq_tab[t % 8] : 0;
      check("pattern", int'({o2, o1, o0}), ep);
      check("out_val", int'(val), int'(ph == 1));
      check("exp", int'(ex), int'($countones(ep) >= 2));
      check("busy", int'(busy), int'(ph == 1));
      check("done", int'(done), int'(ph == 2));
      check("pair_count", int'(pc), imin(cnt, 255));
      check("sat_count", int'(b_pc), imin(cnt, 3));
      check("sat_busy", int'(b_busy), int'(ph == 1));
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic start_run(input int r);
    start = 1'b1;
    reps = 4'(r);
    done_cnt = 0;
    busy_cnt = 0;
    dut_acc.delete();
    tick();
    start = 1'b0;
  endtask

  // rdy_mode: 0 held high, 1 repeating 1,0,0, 2 random. noise drives start/reps during the run.
  task automatic run_to_idle(input int rdy_mode, input bit noise, input int max_cycles);
    int i;
    for (i = 0; i < max_cycles && ph != 0; i++) begin
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = (i % 3 == 0);
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        reps  = 4'($urandom_range(0, 15));
      end
      tick();
    end
    start = 1'b0;
    if (ph != 0) check("timeout", 0, 1);
  endtask

  task automatic check_sweeps(input int r);
    check("xfer_total", dut_acc.size(), 8 * r);
    check("done_pulses", done_cnt, 1);
    check("final_count", int'(pc), 4 * r);
    for (int i = 1; i < dut_acc.size(); i++) begin
`ifdef PATGEN_GRAY_EN
      check("gray_step", $countones(dut_acc[i] ^ dut_acc[i-1]), 1);
`else
      check("bin_step", dut_acc[i], (dut_acc[i-1] + 1) % 8);
`endif
    end
  endtask

  initial begin
`ifdef PATGEN_GRAY_EN
    seq_tab = '{0, 1, 3, 2, 6, 7, 5, 4};
`else
    seq_tab = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    ph = 0; t = 0; cnt = 0; total = 0;
    rst_n = 1'b0; start = 1'b0; reps = 4'd0; out_rdy = 1'b0;
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Single sweep, consumer always ready.
    out_rdy = 1'b1;
    start_run(1);
    run_to_idle(0, 1'b0, 50);
    check_sweeps(1);
    check("r1_busy_cycles", busy_cnt, 8);
    check("r1_sat", int'(b_pc), 3);

    // Three sweeps; busy lasts exactly 24 cycles.
    start_run(3);
    run_to_idle(0, 1'b0, 100);
    check_sweeps(3);
    check("r3_busy_cycles", busy_cnt, 24);

    // Back-pressure with a 1,0,0 ready pattern.
    start_run(2);
    run_to_idle(1, 1'b0, 200);
    check_sweeps(2);

    // Reset lands on the 5th transfer.
    out_rdy = 1'b1;
    start_run(1);
    while (ph == 1 && t < 4) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_val", int'(val), 0);
    check("rst_mid_count", int'(pc), 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("rst_no_done", done_cnt, 0);
    start_run(1);
    check("restart_first", int'({o2, o1, o0}), 0);
    run_to_idle(0, 1'b0, 50);
    check_sweeps(1);

    // reps=0 start is ignored.
    start_run(0);
    tick();
    tick();
    check("zero_busy", busy_cnt, 0);
    check("zero_done", done_cnt, 0);

    // start/reps noise during a run has no effect.
    start_run(2);
    run_to_idle(0, 1'b1, 100);
    check_sweeps(2);

    // Randomized runs.
    for (int k = 0; k < 8; k++) begin
      int r;
      r = $urandom_range(1, 4);
      start_run(r);
      run_to_idle(2, 1'($urandom_range(0, 1)), 400);
      check_sweeps(r);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
